// File: rtl/vx_mem_req_arbiter.sv
// rtl/vx_mem_req_arbiter.sv - round-robin arbiter sharing one mem_req/mem_rsp port among NUM_REQS requesters
module vx_mem_req_arbiter #(
  parameter  int NUM_REQS    = 2,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int DATA_WIDTH  = 32,
  parameter  int TAG_WIDTH   = 8,
  parameter  int MAX_PENDING = 4,
  localparam int LOG         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int BE_W        = DATA_WIDTH / 8,
  localparam int OTAG_W      = TAG_WIDTH + LOG,
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            in_req_valid,
  input  logic [NUM_REQS-1:0]            in_req_rw,
  input  logic [NUM_REQS*BE_W-1:0]       in_req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] in_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] in_req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  in_req_tag,
  output logic [NUM_REQS-1:0]            in_req_ready,
  output logic [NUM_REQS-1:0]            in_rsp_valid,
  output logic [DATA_WIDTH-1:0]          in_rsp_data,
  output logic [TAG_WIDTH-1:0]           in_rsp_tag,
  input  logic [NUM_REQS-1:0]            in_rsp_ready,
  output logic                           out_req_valid,
  output logic                           out_req_rw,
  output logic [BE_W-1:0]                out_req_byteen,
  output logic [ADDR_WIDTH-1:0]          out_req_addr,
  output logic [DATA_WIDTH-1:0]          out_req_data,
  output logic [OTAG_W-1:0]              out_req_tag,
  input  logic                           out_req_ready,
  input  logic                           out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          out_rsp_data,
  input  logic [OTAG_W-1:0]              out_rsp_tag,
  output logic                           out_rsp_ready,
  output logic                           busy
);

  localparam logic [LOG:0]     C_NREQ = (LOG+1)'(NUM_REQS);
  localparam logic [LOG-1:0]   C_LAST = LOG'(NUM_REQS - 1);
  localparam logic [CNT_W-1:0] C_MAXP = CNT_W'(MAX_PENDING);

  logic                  r_valid;
  logic                  r_rw;
  logic [BE_W-1:0]       r_byteen;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [OTAG_W-1:0]     r_tag;
  logic [LOG-1:0]        r_rr_ptr;
  logic [CNT_W-1:0]      r_pending;

  logic                  w_slot_free;
  logic                  w_pend_ok;
  logic [NUM_REQS-1:0]   w_eligible;
  logic [LOG:0]          w_scan;
  logic                  w_grant_valid;
  logic [LOG-1:0]        w_grant_idx;
  logic                  w_sel_rw;
  logic [BE_W-1:0]       w_sel_byteen;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [TAG_WIDTH-1:0]  w_sel_tag;
  logic [LOG-1:0]        w_rsp_idx;
  logic                  w_rsp_in_range;
  logic                  w_rsp_ready_raw;
  logic                  w_rsp_fire;
  logic                  w_read_grant;

  assign w_slot_free = !r_valid || out_req_ready;
  assign w_pend_ok   = (r_pending < C_MAXP);

  // A requester may compete if it has a write, or a read while the outstanding-read budget allows
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_eligible[i] = in_req_valid[i] && (in_req_rw[i] || w_pend_ok);
    end
  end

  // Round-robin scan starting at the pointer; the first eligible requester wins the free slot
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_scan        = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (LOG+1)'(k);
      if (w_scan >= C_NREQ) begin
        w_scan = w_scan - C_NREQ;
      end
      if (!w_grant_valid && w_slot_free && w_eligible[w_scan[LOG-1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_scan[LOG-1:0];
      end
    end
  end

  // Select the winner's fields and drive the one-hot grant back to the requesters
  always_comb begin
    in_req_ready = '0;
    w_sel_rw     = 1'b0;
    w_sel_byteen = '0;
    w_sel_addr   = '0;
    w_sel_data   = '0;
    w_sel_tag    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_grant_idx == LOG'(i)) begin
        in_req_ready[i] = reset && w_grant_valid;
        w_sel_rw        = in_req_rw[i];
        w_sel_byteen    = in_req_byteen[i*BE_W +: BE_W];
        w_sel_addr      = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data      = in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_tag       = in_req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign w_rsp_idx      = out_rsp_tag[OTAG_W-1:TAG_WIDTH];
  assign w_rsp_in_range = ({1'b0, w_rsp_idx} < C_NREQ);

  // Route the response by the index field; out-of-range indices are accepted and dropped
  always_comb begin
    in_rsp_valid    = '0;
    w_rsp_ready_raw = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_rsp_idx == LOG'(i)) begin
        in_rsp_valid[i] = reset && out_rsp_valid;
        w_rsp_ready_raw = in_rsp_ready[i];
      end
    end
    if (!w_rsp_in_range) begin
      w_rsp_ready_raw = 1'b1;
    end
  end

  assign out_rsp_ready = reset && w_rsp_ready_raw;
  assign in_rsp_data   = out_rsp_data;
  assign in_rsp_tag    = out_rsp_tag[TAG_WIDTH-1:0];
  assign w_rsp_fire    = out_rsp_valid && w_rsp_ready_raw;
  assign w_read_grant  = w_grant_valid && !w_sel_rw;

  // Output register: loads on a grant, holds under backpressure, empties after a handshake
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid  <= 1'b0;
      r_rw     <= 1'b0;
      r_byteen <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_tag    <= '0;
      r_rr_ptr <= '0;
    end else if (w_grant_valid) begin
      r_valid  <= 1'b1;
      r_rw     <= w_sel_rw;
      r_byteen <= w_sel_byteen;
      r_addr   <= w_sel_addr;
      r_data   <= w_sel_data;
      r_tag    <= {w_grant_idx, w_sel_tag};
      r_rr_ptr <= (w_grant_idx == C_LAST) ? '0 : w_grant_idx + LOG'(1);
    end else if (w_slot_free) begin
      r_valid  <= 1'b0;
    end
  end

  // Outstanding-read counter; a simultaneous issue and return cancel, and returns floor at zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= '0;
    end else if (w_read_grant && !w_rsp_fire) begin
      r_pending <= r_pending + CNT_W'(1);
    end else if (w_rsp_fire && !w_read_grant && (r_pending != '0)) begin
      r_pending <= r_pending - CNT_W'(1);
    end
  end

  assign out_req_valid  = r_valid;
  assign out_req_rw     = r_rw;
  assign out_req_byteen = r_byteen;
  assign out_req_addr   = r_addr;
  assign out_req_data   = r_data;
  assign out_req_tag    = r_tag;
  assign busy           = reset && (r_valid || (r_pending != '0));

endmodule

// File: tb/tb_vx_mem_req_arbiter.sv
// tb/tb_vx_mem_req_arbiter.sv - bench for vx_mem_req_arbiter with directed steps and a randomized phase
module tb_vx_mem_req_arbiter;
  localparam int N    = 3;
  localparam int MAXP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    in_req_valid, in_req_rw;
  logic [11:0]   in_req_byteen;
  logic [95:0]   in_req_addr, in_req_data;
  logic [23:0]   in_req_tag;
  logic [2:0]    in_req_ready, in_rsp_valid, in_rsp_ready;
  logic [31:0]   in_rsp_data;
  logic [7:0]    in_rsp_tag;
  logic          out_req_valid, out_req_rw, out_req_ready;
  logic [3:0]    out_req_byteen;
  logic [31:0]   out_req_addr, out_req_data;
  logic [9:0]    out_req_tag, out_rsp_tag;
  logic          out_rsp_valid, out_rsp_ready, busy;
  logic [31:0]   out_rsp_data;

  vx_mem_req_arbiter #(
    .NUM_REQS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(8), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_byteen(in_req_byteen),
    .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready), .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data),
    .in_rsp_tag(in_rsp_tag), .in_rsp_ready(in_rsp_ready),
    .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_byteen(out_req_byteen),
    .out_req_addr(out_req_addr), .out_req_data(out_req_data), .out_req_tag(out_req_tag),
    .out_req_ready(out_req_ready), .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data),
    .out_rsp_tag(out_rsp_tag), .out_rsp_ready(out_rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int          m_ptr, m_pend;
  bit          m_valid, m_rw;
  logic [9:0]  m_tag;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_be;

  // values sampled mid-cycle for the directed checks
  logic [2:0]  s_ready, s_rsp_valid;
  logic        s_ordy, s_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input bit v, input bit rw, input logic [7:0] tag);
    in_req_valid[i]          = v;
    in_req_rw[i]             = rw;
    in_req_tag[i*8 +: 8]     = tag;
    in_req_addr[i*32 +: 32]  = 32'h1000_0000 + 32'(i * 16) + {24'h0, tag};
    in_req_data[i*32 +: 32]  = 32'hA000_0000 + {24'h0, tag};
    in_req_byteen[i*4 +: 4]  = 4'hF - 4'(i);
  endtask

  task automatic clear_all();
    in_req_valid = '0; in_req_rw = '0; in_req_byteen = '0; in_req_addr = '0;
    in_req_data = '0; in_req_tag = '0; in_rsp_ready = '0; out_req_ready = 1'b0;
    out_rsp_valid = 1'b0; out_rsp_data = '0; out_rsp_tag = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registers after the edge
  task automatic tick();
    int g, i, idx;
    bit free, inc, dec;
    logic [2:0] e_ready, e_rv;
    logic e_ordy, e_busy;
    @(negedge clk);
    idx = int'(out_rsp_tag[9:8]);
    g = -1; free = 0;
    if (!reset) begin
      e_ready = '0; e_rv = '0; e_ordy = 1'b0; e_busy = 1'b0;
    end else begin
      free = !m_valid || out_req_ready;
      if (free) begin
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + k) % N;
          if (g < 0 && in_req_valid[i] && (in_req_rw[i] || m_pend < MAXP)) g = i;
        end
      end
      e_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
      if (idx < N) begin
        e_rv   = out_rsp_valid ? 3'(1 << idx) : 3'b000;
        e_ordy = in_rsp_ready[idx];
      end else begin
        e_rv = '0; e_ordy = 1'b1;
      end
      e_busy = m_valid || (m_pend != 0);
    end
    s_ready = in_req_ready; s_rsp_valid = in_rsp_valid; s_ordy = out_rsp_ready; s_busy = busy;
    check("in_req_ready", 64'(in_req_ready), 64'(e_ready));
    check("in_rsp_valid", 64'(in_rsp_valid), 64'(e_rv));
    check("out_rsp_ready", 64'(out_rsp_ready), 64'(e_ordy));
    check("busy", 64'(busy), 64'(e_busy));
    check("in_rsp_tag", 64'(in_rsp_tag), 64'(out_rsp_tag & 10'hFF));
    check("in_rsp_data", 64'(in_rsp_data), 64'(out_rsp_data));
    if (!reset) begin
      m_valid = 0; m_rw = 0; m_tag = '0; m_addr = '0; m_data = '0; m_be = '0;
      m_ptr = 0; m_pend = 0;
    end else begin
      inc = (g >= 0) && !in_req_rw[g];
      dec = out_rsp_valid && e_ordy;
      if (g >= 0) begin
        m_valid = 1; m_rw = in_req_rw[g];
        m_tag  = 10'(g * 256) + {2'b00, in_req_tag[g*8 +: 8]};
        m_addr = in_req_addr[g*32 +: 32];
        m_data = in_req_data[g*32 +: 32];
        m_be   = in_req_byteen[g*4 +: 4];
        m_ptr  = (g + 1) % N;
      end else if (free) begin
        m_valid = 0;
      end
      if (inc && !dec) m_pend++;
      else if (dec && !inc && m_pend > 0) m_pend--;
    end
    @(posedge clk);
    #1;
    check("out_req_valid", 64'(out_req_valid), 64'(m_valid));
    check("out_req_rw", 64'(out_req_rw), 64'(m_rw));
    check("out_req_tag", 64'(out_req_tag), 64'(m_tag));
    check("out_req_addr", 64'(out_req_addr), 64'(m_addr));
    check("out_req_data", 64'(out_req_data), 64'(m_data));
    check("out_req_byteen", 64'(out_req_byteen), 64'(m_be));
  endtask

  initial begin
    m_ptr = 0; m_pend = 0; m_valid = 0; m_rw = 0; m_tag = '0; m_addr = '0; m_data = '0; m_be = '0;
    reset = 1'b0;
    clear_all();
    tick();
    tick();
    check("reset_out_valid", 64'(out_req_valid), 64'(0));
    check("reset_busy", 64'(s_busy), 64'(0));

    // alternating grants between two reading requesters
    reset = 1'b1;
    set_req(0, 1, 0, 8'h11);
    set_req(1, 1, 0, 8'h22);
    out_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rr_grant", 64'(s_ready), 64'(3'(1 << (c % 2))));
      check("rr_tag_idx", 64'(out_req_tag[9:8]), 64'(c % 2));
    end

    // backpressure holds the output register
    reset = 1'b0; clear_all(); tick();
    reset = 1'b1;
    set_req(0, 1, 0, 8'h05);
    tick();
    check("bp_first_grant", 64'(s_ready), 64'(3'b001));
    set_req(0, 1, 0, 8'h06);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_no_grant", 64'(s_ready), 64'(3'b000));
      check("bp_held_tag", 64'(out_req_tag), 64'(10'h005));
    end
    out_req_ready = 1'b1;
    tick();
    check("bp_second_grant", 64'(s_ready), 64'(3'b001));
    check("bp_second_tag", 64'(out_req_tag), 64'(10'h006));
    in_req_valid = '0;
    tick();

    // outstanding-read limit blocks reads but not writes
    reset = 1'b0; clear_all(); tick();
    reset = 1'b1;
    out_req_ready = 1'b1;
    set_req(0, 1, 0, 8'h40);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("lim_read_grant", 64'(s_ready), 64'(3'b001));
    end
    set_req(1, 1, 1, 8'h50);
    tick();
    check("lim_write_grant", 64'(s_ready), 64'(3'b010));
    in_req_valid[1] = 1'b0;
    tick();
    check("lim_read_stall", 64'(s_ready), 64'(3'b000));
    out_rsp_valid = 1'b1; out_rsp_tag = 10'h033; in_rsp_ready = 3'b001;
    tick();
    check("lim_rsp_accept", 64'(s_ordy), 64'(1));
    check("lim_stall_on_rsp", 64'(s_ready), 64'(3'b000));
    out_rsp_valid = 1'b0; in_rsp_ready = '0;
    tick();
    check("lim_read_resumes", 64'(s_ready), 64'(3'b001));

    // response routed to requester 1 waits for its ready
    in_req_valid = '0;
    out_rsp_valid = 1'b1; out_rsp_tag = 10'h12A; out_rsp_data = 32'hDEADBEEF; in_rsp_ready = 3'b000;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rsp_valid_held", 64'(s_rsp_valid), 64'(3'b010));
      check("rsp_tag", 64'(in_rsp_tag), 64'(8'h2A));
      check("rsp_not_ready", 64'(s_ordy), 64'(0));
    end
    in_rsp_ready = 3'b010;
    tick();
    check("rsp_ready", 64'(s_ordy), 64'(1));
    check("rsp_data", 64'(in_rsp_data), 64'(32'hDEADBEEF));
    out_rsp_valid = 1'b0; in_rsp_ready = '0;

    // out-of-range response index is dropped but still retires a pending read
    reset = 1'b0; clear_all(); tick();
    reset = 1'b1;
    out_req_ready = 1'b1;
    set_req(2, 1, 0, 8'h77);
    tick();
    in_req_valid = '0;
    tick();
    out_rsp_valid = 1'b1; out_rsp_tag = 10'h3C4;
    tick();
    check("oor_ready", 64'(s_ordy), 64'(1));
    check("oor_no_valid", 64'(s_rsp_valid), 64'(3'b000));
    check("oor_busy_before", 64'(s_busy), 64'(1));
    out_rsp_valid = 1'b0;
    tick();
    check("oor_busy_after", 64'(s_busy), 64'(0));

    // reset mid-operation discards the held request and pending count
    reset = 1'b0; clear_all(); tick();
    reset = 1'b1;
    out_req_ready = 1'b1;
    set_req(0, 1, 0, 8'h01);
    tick();
    in_req_valid[0] = 1'b0;
    set_req(1, 1, 0, 8'h02);
    tick();
    in_req_valid[1] = 1'b0;
    out_req_ready = 1'b0;
    tick();
    check("mid_busy", 64'(s_busy), 64'(1));
    check("mid_valid", 64'(out_req_valid), 64'(1));
    reset = 1'b0;
    set_req(0, 1, 0, 8'h03);
    set_req(1, 1, 0, 8'h04);
    tick();
    check("mid_reset_ready", 64'(s_ready), 64'(3'b000));
    check("mid_reset_valid", 64'(out_req_valid), 64'(0));
    reset = 1'b1;
    in_req_valid[0] = 1'b0;
    tick();
    check("post_reset_busy", 64'(s_busy), 64'(0));
    check("post_reset_grant", 64'(s_ready), 64'(3'b010));

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      reset         = ($urandom_range(0, 99) != 0);
      in_req_valid  = 3'($urandom);
      in_req_rw     = 3'($urandom);
      in_req_byteen = 12'($urandom);
      in_req_tag    = 24'($urandom);
      in_req_addr   = {$urandom, $urandom, $urandom};
      in_req_data   = {$urandom, $urandom, $urandom};
      out_req_ready = ($urandom_range(0, 3) != 0);
      out_rsp_valid = 1'($urandom);
      out_rsp_tag   = 10'($urandom);
      out_rsp_data  = $urandom;
      in_rsp_ready  = 3'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
